// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   NREG / REG_W      : architectural register count and index width
//   FWD_*             : EX operand forwarding select encodings
//   state_t           : hazard controller FSM states
//   shadow_t          : one in-flight destination tracking entry
//   fwd_select()      : forwarding priority (EX/MEM over MEM/WB over RF)
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int unsigned NREG  = 32;
    localparam int unsigned REG_W = $clog2(NREG);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_wr;
        logic             mem_reg;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '0;

    // The younger producer (in EX) always wins over the older one (in MEM).
    function automatic logic [1:0] fwd_select(input logic ex_hit, input logic mem_hit);
        if (ex_hit)       return FWD_EXMEM;
        else if (mem_hit) return FWD_MEMWB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational comparison of one ID source operand against one shadow entry.
//   use_src  in  source operand is actually read by the instruction
//   src      in  source register index
//   entry    in  shadow pipeline entry (valid, rd, reg_wr, mem_reg)
//   hit      out entry produces the value this source needs
//   load_hit out hit, and the producer is a load
// Register x0 never matches.
// -----------------------------------------------------------------------------
module hazard_match
    import pipe_ctrl_pkg::*;
(
    input  logic             use_src,
    input  logic [REG_W-1:0] src,
    input  shadow_t          entry,
    output logic             hit,
    output logic             load_hit
);

    always_comb begin
        hit      = use_src && (src != '0) && entry.valid && entry.reg_wr && (entry.rd == src);
        load_hit = hit && entry.mem_reg;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage core. Tracks in-flight
// destinations in a shadow EX/MEM/WB pipeline, selects EX operand forwarding,
// inserts the load-use bubble and squashes younger work on a taken branch.
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid_in                 ID holds a real instruction
//   id_rs1_in / id_rs2_in       ID source indices
//   id_use_rs1_in/id_use_rs2_in instruction reads that source
//   id_rd_in, id_reg_wr_in      ID destination and write enable
//   id_mem_reg_in               ID instruction is a load
//   ex_branch_taken_in          taken branch/jump resolved in EX
//   stall_out                   hold PC and IF/ID, bubble into ID/EX
//   flush_ifid_out              squash IF/ID
//   flush_idex_out              bubble into ID/EX
//   fwd_rs1_out / fwd_rs2_out   registered EX forwarding selects
// Optional (macro HAZARD_PERF_CNT_EN):
//   stall_cnt_out / flush_cnt_out  wrapping counts of stall / flush cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_in,
    input  logic [REG_W-1:0] id_rs1_in,
    input  logic [REG_W-1:0] id_rs2_in,
    input  logic             id_use_rs1_in,
    input  logic             id_use_rs2_in,
    input  logic [REG_W-1:0] id_rd_in,
    input  logic             id_reg_wr_in,
    input  logic             id_mem_reg_in,
    input  logic             ex_branch_taken_in,
    output logic             stall_out,
    output logic             flush_ifid_out,
    output logic             flush_idex_out,
    output logic [1:0]       fwd_rs1_out,
    output logic [1:0]       fwd_rs2_out
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt_out,
    output logic [31:0]      flush_cnt_out
`endif
);

    state_t  state;
    shadow_t sh_ex, sh_mem, sh_wb;
    shadow_t id_entry;

    logic id_active;
    logic use1, use2;
    logic ex1_hit, ex2_hit, mem1_hit, mem2_hit;
    logic ex1_load, ex2_load, mem1_load, mem2_load;
    logic load_use;

    // The slot right after a flush holds a squashed fetch, whatever ID claims.
    always_comb begin
        id_active = id_valid_in && (state != FLUSH);
        use1      = id_active && id_use_rs1_in;
        use2      = id_active && id_use_rs2_in;
        id_entry  = '{valid: id_active, rd: id_rd_in, reg_wr: id_reg_wr_in, mem_reg: id_mem_reg_in};
    end

    hazard_match u_ex_rs1 (.use_src(use1), .src(id_rs1_in), .entry(sh_ex),
                           .hit(ex1_hit), .load_hit(ex1_load));
    hazard_match u_ex_rs2 (.use_src(use2), .src(id_rs2_in), .entry(sh_ex),
                           .hit(ex2_hit), .load_hit(ex2_load));
    hazard_match u_mem_rs1 (.use_src(use1), .src(id_rs1_in), .entry(sh_mem),
                            .hit(mem1_hit), .load_hit(mem1_load));
    hazard_match u_mem_rs2 (.use_src(use2), .src(id_rs2_in), .entry(sh_mem),
                            .hit(mem2_hit), .load_hit(mem2_load));

    // A load in MEM is forwarded from write-back, so only an EX load stalls.
    // sh_wb is retired state kept for visibility; nothing downstream reads it.
    logic unused_bits;
    assign unused_bits = ^{sh_wb, mem1_load, mem2_load};

    // The STALL gate keeps one ID instruction from stalling twice; the taken
    // branch overrides the stall since the stalled instruction is squashed.
    always_comb begin
        load_use       = (ex1_load || ex2_load) && (state != STALL);
        stall_out      = load_use && !ex_branch_taken_in;
        flush_ifid_out = ex_branch_taken_in;
        flush_idex_out = ex_branch_taken_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            sh_ex       <= SHADOW_BUBBLE;
            sh_mem      <= SHADOW_BUBBLE;
            sh_wb       <= SHADOW_BUBBLE;
            fwd_rs1_out <= FWD_RF;
            fwd_rs2_out <= FWD_RF;
        end else begin
            sh_wb  <= sh_mem;
            sh_mem <= sh_ex;
            sh_ex  <= (stall_out || flush_idex_out) ? SHADOW_BUBBLE : id_entry;

            // Held selects during a stall belong to the instruction still in EX.
            if (flush_idex_out) begin
                fwd_rs1_out <= FWD_RF;
                fwd_rs2_out <= FWD_RF;
            end else if (!stall_out) begin
                fwd_rs1_out <= fwd_select(ex1_hit, mem1_hit);
                fwd_rs2_out <= fwd_select(ex2_hit, mem2_hit);
            end

            if (ex_branch_taken_in)
                state <= FLUSH;
            else if (stall_out)
                state <= STALL;
            else
                state <= RUN;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_out <= '0;
            flush_cnt_out <= '0;
        end else begin
            if (stall_out)      stall_cnt_out <= stall_cnt_out + 32'd1;
            if (flush_ifid_out) flush_cnt_out <= flush_cnt_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl: each step presents one ID instruction after
// a falling edge, checks the combinational stall/flush outputs, then checks
// the registered forwarding selects just after the rising edge.
// Optional counters are checked when HAZARD_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, use1, use2, reg_wr, mem_reg, br;
    logic [4:0] rs1, rs2, rd;
    logic       stall, flush_ifid, flush_idex;
    logic [1:0] fwd1, fwd2;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_valid_in       (id_valid),
        .id_rs1_in         (rs1),
        .id_rs2_in         (rs2),
        .id_use_rs1_in     (use1),
        .id_use_rs2_in     (use2),
        .id_rd_in          (rd),
        .id_reg_wr_in      (reg_wr),
        .id_mem_reg_in     (mem_reg),
        .ex_branch_taken_in(br),
        .stall_out         (stall),
        .flush_ifid_out    (flush_ifid),
        .flush_idex_out    (flush_idex),
        .fwd_rs1_out       (fwd1),
        .fwd_rs2_out       (fwd2)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt_out     (stall_cnt),
        .flush_cnt_out     (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one ID instruction after the falling edge.
    task automatic drive(input logic v, input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2, input logic [4:0] d,
                         input logic wr, input logic mem, input logic b);
        @(negedge clk);
        id_valid = v; rs1 = s1; use1 = u1; rs2 = s2; use2 = u2;
        rd = d; reg_wr = wr; mem_reg = mem; br = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        drive(1'b1, s1, 1'b1, s2, 1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [4:0] d, input logic [4:0] base);
        drive(1'b1, base, 1'b1, 5'd0, 1'b0, d, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        id_valid = 0; rs1 = 0; rs2 = 0; use1 = 0; use2 = 0;
        rd = 0; reg_wr = 0; mem_reg = 0; br = 0;

        // Reset state
        #12;
        chk("rst_stall", stall, 1'b0);
        chk("rst_flush_ifid", flush_ifid, 1'b0);
        chk("rst_flush_idex", flush_idex, 1'b0);
        chk("rst_fwd1", fwd1, 2'b00);
        chk("rst_fwd2", fwd2, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // add x5,x1,x2 ; add x6,x5,x1 -> EX/MEM forward on rs1
        alu(5'd5, 5'd1, 5'd2);
        tick();
        chk("a_fwd1", fwd1, 2'b00);
        alu(5'd6, 5'd5, 5'd1);
        chk("b_stall", stall, 1'b0);
        tick();
        chk("b_fwd1", fwd1, 2'b10);
        chk("b_fwd2", fwd2, 2'b00);

        // add x5 ; nop ; sub x7,x1,x5 -> MEM/WB forward on rs2
        alu(5'd5, 5'd1, 5'd2);
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("nop_fwd1", fwd1, 2'b00);
        alu(5'd7, 5'd1, 5'd5);
        tick();
        chk("e_fwd1", fwd1, 2'b00);
        chk("e_fwd2", fwd2, 2'b01);

        // Both sources forwarded from different stages
        alu(5'd5, 5'd1, 5'd2);
        tick();
        alu(5'd8, 5'd5, 5'd7);
        tick();
        chk("g_fwd1", fwd1, 2'b10);
        chk("g_fwd2", fwd2, 2'b01);

        // x8 in EX and MEM: EX wins; x0 read never forwards
        alu(5'd8, 5'd1, 5'd1);
        tick();
        alu(5'd10, 5'd8, 5'd0);
        tick();
        chk("i_fwd1_prio", fwd1, 2'b10);
        chk("i_fwd2_x0", fwd2, 2'b00);

        // lw x5,0(x10) ; add x6,x5,x5 -> one stall, then MEM/WB forward
        load(5'd5, 5'd10);
        chk("j_stall", stall, 1'b0);
        tick();
        chk("j_fwd1", fwd1, 2'b10);
        alu(5'd6, 5'd5, 5'd5);
        chk("k_stall", stall, 1'b1);
        chk("k_flush", flush_idex, 1'b0);
        tick();
        chk("k_hold_fwd1", fwd1, 2'b10);
        chk("k_hold_fwd2", fwd2, 2'b00);
        alu(5'd6, 5'd5, 5'd5);
        chk("k2_stall", stall, 1'b0);
        tick();
        chk("k2_fwd1", fwd1, 2'b01);
        chk("k2_fwd2", fwd2, 2'b01);

        // lw x0 ; add x11,x0,x0 -> no stall, no forwarding
        load(5'd0, 5'd1);
        tick();
        alu(5'd11, 5'd0, 5'd0);
        chk("m_stall_x0", stall, 1'b0);
        tick();
        chk("m_fwd1", fwd1, 2'b00);
        chk("m_fwd2", fwd2, 2'b00);

        // lw x12,0(x11) ; load-use dependent coincident with taken branch
        load(5'd12, 5'd11);
        tick();
        chk("n_fwd1", fwd1, 2'b10);
        drive(1'b1, 5'd12, 1'b1, 5'd1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);
        chk("o_stall", stall, 1'b0);
        chk("o_flush_ifid", flush_ifid, 1'b1);
        chk("o_flush_idex", flush_idex, 1'b1);
        tick();
        chk("o_fwd1", fwd1, 2'b00);
        chk("o_fwd2", fwd2, 2'b00);

        // Slot after the flush is ignored even if ID claims valid
        alu(5'd14, 5'd12, 5'd12);
        chk("p_stall", stall, 1'b0);
        chk("p_flush", flush_ifid, 1'b0);
        tick();
        chk("p_fwd1", fwd1, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        chk("p_stall_cnt", stall_cnt, 32'd1);
        chk("p_flush_cnt", flush_cnt, 32'd1);
`endif

        // Reset asserted in the middle of a STALL cycle
        alu(5'd20, 5'd1, 5'd1);
        tick();
        load(5'd15, 5'd20);
        tick();
        alu(5'd16, 5'd15, 5'd0);
        chk("r_stall", stall, 1'b1);
        tick();
        chk("r_hold_fwd1", fwd1, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("r_rst_stall", stall, 1'b0);
        chk("r_rst_fwd1", fwd1, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        chk("r_rst_stall_cnt", stall_cnt, 32'd0);
        chk("r_rst_flush_cnt", flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        alu(5'd17, 5'd15, 5'd15);
        chk("s_stall", stall, 1'b0);
        tick();
        chk("s_fwd1", fwd1, 2'b00);
        chk("s_fwd2", fwd2, 2'b00);

        // Back-to-back load-use chain: lw x5 ; lw x6,0(x5) ; add x7,x6,x0
        load(5'd5, 5'd1);
        tick();
        load(5'd6, 5'd5);
        chk("u_stall", stall, 1'b1);
        tick();
        load(5'd6, 5'd5);
        chk("u2_stall", stall, 1'b0);
        tick();
        chk("u2_fwd1", fwd1, 2'b01);
        alu(5'd7, 5'd6, 5'd0);
        chk("v_stall", stall, 1'b1);
        tick();
        alu(5'd7, 5'd6, 5'd0);
        chk("v2_stall", stall, 1'b0);
        tick();
        chk("v2_fwd1", fwd1, 2'b01);
`ifdef HAZARD_PERF_CNT_EN
        chk("v_stall_cnt", stall_cnt, 32'd2);
        chk("v_flush_cnt", flush_cnt, 32'd0);
`endif

        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
